// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums, plus
// the helper that classifies an opcode as multi-cycle (shift-add / restoring divide).
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_MULHU = 4'b1001,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Takes the raw opcode bits so undefined codes never pass through an enum cast.
  function automatic logic is_iter(input logic [OP_W-1:0] op);
    logic r_res;
    r_res = 1'b0;
    case (op)
      OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: r_res = 1'b1;
      default: r_res = 1'b0;
    endcase
    return r_res;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: 1 bit per cycle shift-add multiply or restoring unsigned divide.
// result_o is the post-step value, so the final iteration's result is visible while done_o=1.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               mul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_mul;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the signed trial.
  assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_mul) begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      w_hi_next = w_trial[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_next = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
      w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_mul  <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (abort_i) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i) begin
      r_hi   <= '0;
      r_lo   <= a_i;
      r_b    <= b_i;
      r_mul  <= mul_i;
      r_cnt  <= CNT_W'(WIDTH - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_hi <= w_hi_next;
      r_lo <= w_lo_next;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_busy && (r_cnt == '0);
  assign result_o = {w_hi_next, w_lo_next};

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32 execute ALU with valid/ready handshake and registered results.
// Optional ALU_EARLY_EXIT_EN: degenerate iterative ops (b==0, or MUL/MULHU with a==0) finish in 1 cycle.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_num_i,
  input  logic [WIDTH-1:0] b_num_i,
  input  logic [OP_W-1:0]  alu_op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] c_num_o,
  output logic             zero_o,
  output logic             illegal_o
);

  alu_state_e       r_state;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_zero;
  logic             r_illegal;
  logic             r_hi_sel;
  logic             r_neg;

  logic             w_iter;
  logic             w_is_mul;
  logic             w_hi_sel;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_b_zero;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_early;
  logic [WIDTH-1:0] w_early_c;
  logic [WIDTH-1:0] w_single_c;
  logic             w_single_ill;
  logic [WIDTH-1:0] w_fast_c;
  logic             w_start;
  logic             w_iter_busy;
  logic             w_iter_done;
  logic [2*WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_fixed;

  assign w_iter   = is_iter(alu_op_i);
  assign w_is_mul = (alu_op_i == OP_MUL) || (alu_op_i == OP_MULHU);
  assign w_hi_sel = (alu_op_i == OP_MULHU) || (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
  assign w_b_zero = (b_num_i == '0);

  // Signed divide runs on magnitudes; the quotient sign is suppressed for b==0 so DIV yields all-ones.
  assign w_neg_a = ((alu_op_i == OP_DIV) || (alu_op_i == OP_REM)) && a_num_i[WIDTH-1];
  assign w_neg_b = ((alu_op_i == OP_DIV) || (alu_op_i == OP_REM)) && b_num_i[WIDTH-1];
  assign w_mag_a = w_neg_a ? -a_num_i : a_num_i;
  assign w_mag_b = w_neg_b ? -b_num_i : b_num_i;
  assign w_neg   = (alu_op_i == OP_DIV) ? ((w_neg_a ^ w_neg_b) && !w_b_zero) :
                   (alu_op_i == OP_REM) ? w_neg_a : 1'b0;

`ifdef ALU_EARLY_EXIT_EN
  logic w_a_zero;
  assign w_a_zero  = (a_num_i == '0);
  assign w_early   = w_iter && (w_b_zero || (w_is_mul && w_a_zero));
  assign w_early_c = w_is_mul ? '0 : (w_hi_sel ? a_num_i : '1);
`else
  assign w_early   = 1'b0;
  assign w_early_c = '0;
`endif

  always_comb begin
    w_single_c   = '0;
    w_single_ill = 1'b0;
    case (alu_op_i)
      OP_AND:  w_single_c = a_num_i & b_num_i;
      OP_OR:   w_single_c = a_num_i | b_num_i;
      OP_ADD:  w_single_c = a_num_i + b_num_i;
      OP_SUB:  w_single_c = a_num_i - b_num_i;
      OP_SLT:  w_single_c = {{(WIDTH-1){1'b0}}, ($signed(a_num_i) < $signed(b_num_i))};
      default: w_single_ill = !w_iter;
    endcase
  end

  assign w_fast_c = w_early ? w_early_c : w_single_c;
  assign w_start  = (r_state == IDLE) && valid_i && !flush_i && w_iter && !w_early;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (w_start),
    .abort_i  (flush_i),
    .mul_i    (w_is_mul),
    .a_i      (w_is_mul ? a_num_i : w_mag_a),
    .b_i      (w_is_mul ? b_num_i : w_mag_b),
    .busy_o   (w_iter_busy),
    .done_o   (w_iter_done),
    .result_o (w_iter_res)
  );

  assign w_raw   = r_hi_sel ? w_iter_res[2*WIDTH-1:WIDTH] : w_iter_res[WIDTH-1:0];
  assign w_fixed = r_neg ? -w_raw : w_raw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_c       <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_hi_sel  <= 1'b0;
      r_neg     <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_ready <= 1'b0;
            if (w_iter && !w_early) begin
              r_state  <= BUSY;
              r_hi_sel <= w_hi_sel;
              r_neg    <= w_neg;
            end else begin
              r_state   <= DONE;
              r_valid   <= 1'b1;
              r_c       <= w_fast_c;
              r_zero    <= (w_fast_c == '0);
              r_illegal <= w_single_ill;
            end
          end
        end
        BUSY: begin
          if (w_iter_busy && w_iter_done) begin
            r_state   <= DONE;
            r_valid   <= 1'b1;
            r_c       <= w_fixed;
            r_zero    <= (w_fixed == '0);
            r_illegal <= 1'b0;
          end
        end
        DONE: begin
          if (ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = r_valid;
  assign c_num_o   = r_c;
  assign zero_o    = r_zero;
  assign illegal_o = r_illegal;

endmodule
